// File: rtl/writeback_arbiter.sv
// Merges the ALU result path and the buffered memory/multiply path onto the
// single register-file write port, with a bounded-starvation FIFO for memory results.
module writeback_arbiter #(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        aluValid,
  input  logic [4:0]  aluRegisterIndex,
  input  logic [31:0] aluData,
  output logic        aluStall,
  input  logic        memValid,
  output logic        memReady,
  input  logic [4:0]  memRegisterIndex,
  input  logic [31:0] memData,
  output logic [4:0]  writeRegisterIndex,
  output logic [31:0] writeRegisterData,
  output logic        shouldWrite,
  output logic [31:0] pendingMask
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  logic [4:0]       slot_idx_q  [DEPTH];
  logic [4:0]       slot_idx_d  [DEPTH];
  logic [31:0]      slot_data_q [DEPTH];
  logic [31:0]      slot_data_d [DEPTH];
  logic [DEPTH-1:0] slot_vld_q, slot_vld_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [4:0]       wr_idx_q, wr_idx_d;
  logic [31:0]      wr_data_q, wr_data_d;
  logic             wr_en_q, wr_en_d;

  logic fifo_empty, fifo_full, alu_live, forced, pop, push;

  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == FULL_CNT);
    // Index-0 results are architecturally discarded, so they never compete for the port.
    alu_live   = aluValid && (aluRegisterIndex != 5'd0);
    forced     = !fifo_empty && (wait_q == WAIT_MAX);
    pop        = forced || (!alu_live && !fifo_empty);
    memReady   = resetN && !fifo_full;
    push       = memValid && memReady && (memRegisterIndex != 5'd0);
    aluStall   = forced && alu_live;
  end

  always_comb begin
    wr_en_d   = 1'b0;
    wr_idx_d  = wr_idx_q;
    wr_data_d = wr_data_q;
    if (pop) begin
      wr_en_d   = 1'b1;
      wr_idx_d  = slot_idx_q[rd_ptr_q];
      wr_data_d = slot_data_q[rd_ptr_q];
    end else if (alu_live) begin
      wr_en_d   = 1'b1;
      wr_idx_d  = aluRegisterIndex;
      wr_data_d = aluData;
    end
  end

  always_comb begin
    slot_idx_d  = slot_idx_q;
    slot_data_d = slot_data_q;
    slot_vld_d  = slot_vld_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    if (push) begin
      slot_idx_d[wr_ptr_q]  = memRegisterIndex;
      slot_data_d[wr_ptr_q] = memData;
      slot_vld_d[wr_ptr_q]  = 1'b1;
      wr_ptr_d              = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      slot_vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d             = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // The age counter tracks only the current head; a new head starts fresh.
  always_comb begin
    wait_d = wait_q;
    if (pop || fifo_empty) begin
      wait_d = '0;
    end else if (wait_q != WAIT_MAX) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_comb begin
    pendingMask = 32'h0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_vld_q[i]) begin
        pendingMask = pendingMask | (32'h1 << slot_idx_q[i]);
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      slot_vld_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      wait_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_idx_q   <= 5'd0;
      wr_data_q  <= 32'h0;
    end else begin
      slot_vld_q <= slot_vld_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      wait_q     <= wait_d;
      wr_en_q    <= wr_en_d;
      wr_idx_q   <= wr_idx_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // Payload storage is qualified by slot_vld_q, so it needs no reset.
  always_ff @(posedge clk) begin
    slot_idx_q  <= slot_idx_d;
    slot_data_q <= slot_data_d;
  end

  assign shouldWrite        = wr_en_q;
  assign writeRegisterIndex = wr_idx_q;
  assign writeRegisterData  = wr_data_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench for writeback_arbiter: a queue-based reference model predicts
// every register-file write; a monitor pops and compares as writes appear.
module tb_writeback_arbiter;
  localparam int DEPTH    = 4;
  localparam int MAX_WAIT = 8;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        aluValid = 1'b0;
  logic [4:0]  aluRegisterIndex = 5'd0;
  logic [31:0] aluData = 32'h0;
  logic        aluStall;
  logic        memValid = 1'b0;
  logic        memReady;
  logic [4:0]  memRegisterIndex = 5'd0;
  logic [31:0] memData = 32'h0;
  logic [4:0]  writeRegisterIndex;
  logic [31:0] writeRegisterData;
  logic        shouldWrite;
  logic [31:0] pendingMask;

  always #5 clk = ~clk;

  writeback_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .resetN(resetN),
    .aluValid(aluValid), .aluRegisterIndex(aluRegisterIndex), .aluData(aluData),
    .aluStall(aluStall),
    .memValid(memValid), .memReady(memReady),
    .memRegisterIndex(memRegisterIndex), .memData(memData),
    .writeRegisterIndex(writeRegisterIndex), .writeRegisterData(writeRegisterData),
    .shouldWrite(shouldWrite), .pendingMask(pendingMask)
  );

  typedef struct packed { logic [4:0] idx; logic [31:0] data; } wr_t;

  wr_t  model_fifo[$];
  wr_t  exp_q[$];
  int   model_wait = 0;
  int   checks = 0;
  int   passes = 0;
  bit   alu_hold = 1'b0;
  bit   mem_hold = 1'b0;

  logic [31:0] m_mask;
  bit          m_live, m_forced, m_ready, m_pop;
  wr_t         mon_w;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: one step per cycle, evaluated on the falling edge.
  always @(negedge clk) begin
    if (!resetN) begin
      check("rst_shouldWrite", {31'h0, shouldWrite}, 32'h0);
      check("rst_pendingMask", pendingMask, 32'h0);
      check("rst_memReady", {31'h0, memReady}, 32'h0);
      check("rst_aluStall", {31'h0, aluStall}, 32'h0);
      check("rst_index", {27'h0, writeRegisterIndex}, 32'h0);
      check("rst_data", writeRegisterData, 32'h0);
      model_fifo.delete();
      exp_q.delete();
      model_wait = 0;
      alu_hold = 1'b0;
      mem_hold = 1'b0;
    end else begin
      m_mask = 32'h0;
      foreach (model_fifo[i]) m_mask[model_fifo[i].idx] = 1'b1;
      m_ready  = model_fifo.size() < DEPTH;
      m_live   = aluValid && (aluRegisterIndex != 5'd0);
      m_forced = (model_fifo.size() != 0) && (model_wait == MAX_WAIT);
      check("pendingMask", pendingMask, m_mask);
      check("memReady", {31'h0, memReady}, {31'h0, m_ready});
      check("aluStall", {31'h0, aluStall}, {31'h0, m_forced && m_live});
      m_pop = 1'b0;
      if (m_forced || (!m_live && model_fifo.size() != 0)) begin
        exp_q.push_back(model_fifo[0]);
        m_pop = 1'b1;
      end else if (m_live) begin
        exp_q.push_back('{idx: aluRegisterIndex, data: aluData});
      end
      if (m_pop) begin
        void'(model_fifo.pop_front());
        model_wait = 0;
      end else if (model_fifo.size() == 0) model_wait = 0;
      else if (model_wait < MAX_WAIT) model_wait++;
      if (memValid && m_ready && memRegisterIndex != 5'd0)
        model_fifo.push_back('{idx: memRegisterIndex, data: memData});
      alu_hold = m_forced && m_live;
      mem_hold = memValid && !m_ready;
    end
  end

  // Monitor: every presented write must match the oldest predicted write.
  always @(negedge clk) begin
    if (resetN && shouldWrite) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {27'h0, writeRegisterIndex}, 32'hFFFF_FFFF);
      end else begin
        mon_w = exp_q.pop_front();
        check("write_index", {27'h0, writeRegisterIndex}, {27'h0, mon_w.idx});
        check("write_data", writeRegisterData, mon_w.data);
      end
    end
  end

  // Producers hold their inputs while stalled / not accepted.
  task automatic drive(input bit av, input logic [4:0] ai, input logic [31:0] ad,
                       input bit mv, input logic [4:0] mi, input logic [31:0] md);
    @(posedge clk);
    #1;
    if (!alu_hold) begin
      aluValid = av; aluRegisterIndex = ai; aluData = ad;
    end
    if (!mem_hold) begin
      memValid = mv; memRegisterIndex = mi; memData = md;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2 resetN = 1'b1;
    idle(2);

    // ALU only
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
    idle(1); #1;
    check("alu_write_en", {31'h0, shouldWrite}, 32'h1);
    check("alu_write_idx", {27'h0, writeRegisterIndex}, 32'd5);
    check("alu_write_data", writeRegisterData, 32'hDEADBEEF);
    idle(1); #1;
    check("alu_write_drop", {31'h0, shouldWrite}, 32'h0);
    idle(2);

    // Memory only
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h12345678);
    idle(1); #1;
    check("mem_pending", pendingMask, 32'h80);
    check("mem_not_yet", {31'h0, shouldWrite}, 32'h0);
    idle(1); #1;
    check("mem_write_en", {31'h0, shouldWrite}, 32'h1);
    check("mem_write_idx", {27'h0, writeRegisterIndex}, 32'd7);
    check("mem_pending_clear", pendingMask, 32'h0);
    idle(3);

    // Fill under continuous ALU traffic
    for (int k = 0; k < 4; k++)
      drive(1'b1, 5'(k + 1), $urandom, 1'b1, 5'(10 + k), $urandom);
    drive(1'b1, 5'd20, $urandom, 1'b1, 5'd14, 32'h14141414);
    #1 check("fill_memReady_low", {31'h0, memReady}, 32'h0);
    for (int k = 0; k < 40; k++) drive(1'b1, 5'(21 + (k % 10)), $urandom, 1'b0, 5'd0, 32'h0);
    idle(12);

    // Starvation of a single buffered head
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h33333333);
    for (int k = 1; k <= 12; k++) begin
      drive(1'b1, 5'd9, 32'h99990000 + k, 1'b0, 5'd0, 32'h0);
      #1;
      if (k == 8) check("starve_no_stall_yet", {31'h0, aluStall}, 32'h0);
      if (k == 9) check("starve_stall", {31'h0, aluStall}, 32'h1);
      if (k == 10) check("starve_head_written", {27'h0, writeRegisterIndex}, 32'd3);
      if (k == 11) check("starve_held_alu", writeRegisterData, 32'h99990009);
    end
    idle(4);

    // Index 0 on both paths
    drive(1'b1, 5'd0, 32'hAAAA5555, 1'b1, 5'd0, 32'h5555AAAA);
    #1 check("idx0_stall", {31'h0, aluStall}, 32'h0);
    idle(1); #1;
    check("idx0_no_write", {31'h0, shouldWrite}, 32'h0);
    check("idx0_no_pending", pendingMask, 32'h0);
    idle(2);

    // Reset with entries in flight
    for (int k = 0; k < 3; k++)
      drive(1'b1, 5'(1 + k), $urandom, 1'b1, 5'(16 + k), $urandom);
    drive(1'b1, 5'd4, $urandom, 1'b0, 5'd0, 32'h0);
    #1 check("rst_prefill", pendingMask, 32'h0007_0000);
    #1 resetN = 1'b0;
    #1;
    check("async_rst_write", {31'h0, shouldWrite}, 32'h0);
    check("async_rst_mask", pendingMask, 32'h0);
    check("async_rst_ready", {31'h0, memReady}, 32'h0);
    aluValid = 1'b0; memValid = 1'b0;
    repeat (2) @(posedge clk);
    #2 resetN = 1'b1;
    #1 check("rst_release_ready", {31'h0, memReady}, 32'h1);
    idle(2);

    // Randomized traffic in three load phases
    for (int ph = 0; ph < 3; ph++) begin
      for (int k = 0; k < 300; k++) begin
        drive($urandom_range(0, 99) < (ph == 0 ? 90 : ph == 1 ? 50 : 15),
              5'($urandom_range(0, 31)), $urandom,
              $urandom_range(0, 99) < (ph == 0 ? 70 : ph == 1 ? 45 : 30),
              5'($urandom_range(0, 31)), $urandom);
      end
    end
    idle(20);
    check("scoreboard_drained", exp_q.size(), 32'h0);
    check("fifo_drained", pendingMask, 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
